// File: rtl/pkt_xbar_hub.sv
// rtl/pkt_xbar_hub.sv - N-port packet crossbar with per-input FIFOs and round-robin output arbiters
module pkt_xbar_hub #(
  parameter int NPORTS = 5,
  parameter int PWIDTH = 47,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        in_valid,
  output logic [NPORTS-1:0]        in_ready,
  input  logic [NPORTS*PWIDTH-1:0] in_data,
  output logic [NPORTS-1:0]        out_valid,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [NPORTS*PWIDTH-1:0] out_data,
  output logic [15:0]              drop_cnt
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Per-input FIFO storage; pointers carry one extra wrap bit to tell full from empty
  logic [PWIDTH-1:0] mem [NPORTS][DEPTH];
  logic [AW:0]       wr_ptr [NPORTS];
  logic [AW:0]       rd_ptr [NPORTS];
  logic [PWIDTH-1:0] head [NPORTS];
  logic [DEST_W-1:0] head_dest [NPORTS];
  logic [NPORTS-1:0] empty, full, push, pop, drop;

  // req[j][i]: head of input i wants output j
  logic [NPORTS-1:0] req [NPORTS];

  // Arbiter state: last-granted pointer and the grant frozen during a stall
  logic [IW-1:0]     ptr [NPORTS];
  logic [IW-1:0]     lock_idx [NPORTS];
  logic [NPORTS-1:0] locked;
  logic [IW-1:0]     grant [NPORTS];
  logic [NPORTS-1:0] xfer;

  logic [4:0]  ndrop;
  logic [16:0] drop_sum;
  logic [15:0] drop_next;

  // FIFO status, head decode, drop detection and request fan-out
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      empty[i]     = (wr_ptr[i] == rd_ptr[i]);
      full[i]      = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                     (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      head[i]      = mem[i][rd_ptr[i][AW-1:0]];
      head_dest[i] = head[i][PWIDTH-1 -: DEST_W];
      drop[i]      = !empty[i] && (32'(head_dest[i]) >= NPORTS);
    end
    for (int j = 0; j < NPORTS; j++) begin
      for (int i = 0; i < NPORTS; i++) begin
        req[j][i] = !empty[i] && (32'(head_dest[i]) == j);
      end
    end
    in_ready = ~full;
    push     = in_valid & ~full;
  end

  // Per-output grant: held while locked, otherwise first requester after ptr
  always_comb begin
    int idx;
    idx = 0;
    for (int j = 0; j < NPORTS; j++) begin
      grant[j] = lock_idx[j];
      if (!locked[j]) begin
        grant[j] = ptr[j];
        for (int k = NPORTS; k >= 1; k--) begin
          idx = (int'(ptr[j]) + k) % NPORTS;
          if (req[j][idx]) grant[j] = IW'(idx);
        end
      end
      out_valid[j] = req[j][grant[j]];
      xfer[j]      = out_valid[j] & out_ready[j];
    end
  end

  // Output data mux; idle outputs drive zero
  always_comb begin
    out_data = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (out_valid[j]) out_data[j*PWIDTH +: PWIDTH] = head[grant[j]];
    end
  end

  // Pop sources: malformed heads are discarded, granted heads pop on transfer
  always_comb begin
    pop = drop;
    for (int j = 0; j < NPORTS; j++) begin
      if (xfer[j]) pop[grant[j]] = 1'b1;
    end
  end

  // Saturating sum of all drops in this cycle
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NPORTS; i++) begin
      ndrop = ndrop + {4'b0, drop[i]};
    end
    drop_sum  = {1'b0, drop_cnt} + {12'b0, ndrop};
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // FIFO pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
    end
  end

  // FIFO payload write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_data[i*PWIDTH +: PWIDTH];
    end
  end

  // Arbiter pointer advances on transfer; a stalled presentation locks its grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= '0;
      for (int j = 0; j < NPORTS; j++) begin
        ptr[j]      <= IW'(NPORTS - 1);
        lock_idx[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (xfer[j]) begin
          ptr[j]    <= grant[j];
          locked[j] <= 1'b0;
        end else if (out_valid[j]) begin
          locked[j]   <= 1'b1;
          lock_idx[j] <= grant[j];
        end
      end
    end
  end

  // Dropped-packet counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= drop_next;
  end

endmodule

// File: tb/tb_pkt_xbar_hub.sv
// tb/tb_pkt_xbar_hub.sv - directed self-checking bench for pkt_xbar_hub
module tb_pkt_xbar_hub;

  localparam int N  = 5;
  localparam int PW = 47;
  localparam int DW = 4;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid, in_ready, out_valid, out_ready;
  logic [N*PW-1:0] in_data, out_data;
  logic [15:0]     drop_cnt;

  int total = 0;
  int bad   = 0;

  int   sent [N];
  logic acc [N];
  int   ord [3] = '{1, 2, 4};
  int   got;

  // 100 MHz clock
  always #5 clk = ~clk;

  pkt_xbar_hub #(.NPORTS(N), .PWIDTH(PW), .DEST_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  function automatic logic [PW-1:0] mk(input int dest, input int pay);
    logic [PW-1:0] p;
    p = '0;
    p[PW-1 -: DW] = DW'(dest);
    p[31:0] = 32'(pay);
    return p;
  endfunction

  function automatic logic [63:0] od(input int j);
    return 64'(out_data[j*PW +: PW]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int p, input logic v, input logic [PW-1:0] d);
    in_valid[p] = v;
    in_data[p*PW +: PW] = d;
  endtask

  // Directed sequence
  initial begin
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    rst_n     = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'h1F);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_drop_cnt", 64'(drop_cnt), 0);
    chk("rst_out_data", 64'(out_data == '0), 1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_out_valid", 64'(out_valid), 0);
    end

    // Single route and latency
    setp(0, 1'b1, mk(3, 'h1234));
    chk("lat_pre", 64'(out_valid), 0);
    tick();
    in_valid = '0;
    chk("lat_valid", 64'(out_valid), 64'h08);
    chk("lat_data", od(3), 64'(mk(3, 'h1234)));
    tick();
    chk("lat_done", 64'(out_valid), 0);
    chk("lat_in_ready", 64'(in_ready), 64'h1F);

    // Round-robin fairness: ports 1, 2, 4 stream 8 packets each to output 0
    for (int p = 0; p < N; p++) sent[p] = 0;
    got = 0;
    for (int c = 0; c < 200 && got < 24; c++) begin
      if (out_valid[0]) begin
        chk("rr_order", od(0), 64'(mk(0, ord[got % 3] * 16 + got / 3)));
        got++;
      end
      for (int k = 0; k < 3; k++) begin
        if (sent[ord[k]] < 8) setp(ord[k], 1'b1, mk(0, ord[k] * 16 + sent[ord[k]]));
        else                  setp(ord[k], 1'b0, '0);
        acc[ord[k]] = in_valid[ord[k]] & in_ready[ord[k]];
      end
      tick();
      for (int k = 0; k < 3; k++) if (acc[ord[k]]) sent[ord[k]]++;
    end
    in_valid = '0;
    chk("rr_count", 64'(got), 24);
    chk("rr_idle", 64'(out_valid), 0);

    // Backpressure and grant lock on output 1
    out_ready = 5'b11101;
    setp(2, 1'b1, mk(1, 'h200));
    tick();
    in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("lock_stall", od(1), 64'(mk(1, 'h200)));
      tick();
    end
    setp(0, 1'b1, mk(1, 'h100));
    tick();
    in_valid = '0;
    chk("lock_hold1", od(1), 64'(mk(1, 'h200)));
    tick();
    chk("lock_hold2", od(1), 64'(mk(1, 'h200)));
    out_ready = '1;
    chk("lock_first", od(1), 64'(mk(1, 'h200)));
    tick();
    chk("lock_second", od(1), 64'(mk(1, 'h100)));
    tick();
    chk("lock_idle", 64'(out_valid), 0);

    // Full FIFO on input 1 with output 3 stalled
    out_ready = 5'b10111;
    for (int k = 0; k < 4; k++) begin
      setp(1, 1'b1, mk(3, 'h300 + k));
      chk("full_ready", 64'(in_ready[1]), 1);
      tick();
    end
    chk("full_not_ready", 64'(in_ready[1]), 0);
    setp(1, 1'b1, mk(3, 'h304));
    tick();
    tick();
    chk("full_hold", 64'(in_ready[1]), 0);
    chk("full_head", od(3), 64'(mk(3, 'h300)));
    out_ready = '1;
    tick();
    chk("full_pop1", od(3), 64'(mk(3, 'h301)));
    chk("full_ready_again", 64'(in_ready[1]), 1);
    tick();
    in_valid = '0;
    chk("full_pop2", od(3), 64'(mk(3, 'h302)));
    tick();
    chk("full_pop3", od(3), 64'(mk(3, 'h303)));
    tick();
    chk("full_pop4", od(3), 64'(mk(3, 'h304)));
    tick();
    chk("full_idle", 64'(out_valid), 0);

    // Drop of an out-of-range destination
    setp(4, 1'b1, mk(7, 'h777));
    tick();
    in_valid = '0;
    chk("drop_before", 64'(drop_cnt), 0);
    chk("drop_no_valid", 64'(out_valid), 0);
    tick();
    chk("drop_one", 64'(drop_cnt), 1);
    chk("drop_no_valid2", 64'(out_valid), 0);

    // Drive counter to 0xFFFB: five drops per cycle for 13106 cycles
    for (int p = 0; p < N; p++) setp(p, 1'b1, mk(15, p));
    repeat (13106) tick();
    in_valid = '0;
    tick();
    chk("drop_bulk", 64'(drop_cnt), 64'hFFFB);
    chk("drop_bulk_no_valid", 64'(out_valid), 0);
    in_valid = '1;
    tick();
    in_valid = '0;
    tick();
    chk("drop_sat_multi", 64'(drop_cnt), 64'hFFFF);
    for (int k = 0; k < 3; k++) begin
      setp(4, 1'b1, mk(9, k));
      tick();
      in_valid = '0;
      tick();
      chk("drop_sat_hold", 64'(drop_cnt), 64'hFFFF);
    end

    // Reset mid-operation flushes buffered packets
    out_ready = 5'b11011;
    setp(0, 1'b1, mk(2, 'h222));
    tick();
    in_valid = '0;
    chk("mid_valid", 64'(out_valid), 64'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_drop", 64'(drop_cnt), 0);
    chk("mid_rst_ready", 64'(in_ready), 64'h1F);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_flushed", 64'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
